// File: rtl/task_lane_serializer.sv
// Buffers parallel lane vectors in a FIFO and replays them one lane per accepted
// cycle (lane 0 first) as a single valid/last stream with downstream backpressure.
module task_lane_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int INPUT_STREAMS = 8,
    parameter int FIFO_SIZE     = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_WIDTH-1:0]       i_data [INPUT_STREAMS],
    input  logic                        i_valid,
    input  logic                        i_input_last,
    input  logic                        i_out_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_valid,
    output logic                        o_last,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_SIZE):0]  o_fifo_level
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam int IW = $clog2(INPUT_STREAMS);
    localparam int EW = DATA_WIDTH * INPUT_STREAMS + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_STREAMS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [EW-1:0]         r_mem [FIFO_SIZE];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [EW-1:0]         w_wr_entry;
    logic [EW-1:0]         w_rd_entry;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_last_lane;
    logic [DATA_WIDTH-1:0] r_shift [INPUT_STREAMS];
    logic                  r_entry_last;
    logic [IW-1:0]         r_idx;
    logic                  r_overflow;

    // FIFO entry layout: {last flag, lane N-1, ..., lane 0}
    always_comb begin
        w_wr_entry = '0;
        w_wr_entry[EW-1] = i_input_last;
        for (int i = 0; i < INPUT_STREAMS; i++) begin
            w_wr_entry[i*DATA_WIDTH +: DATA_WIDTH] = i_data[i];
        end
    end

    assign w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push      = i_valid && !w_full;
    assign w_accept    = (r_state == S_SHIFT) && i_out_ready;
    assign w_last_lane = (r_idx == LAST_IDX);
    // A pop refills the shift register either from idle or right after the final lane is taken
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || (w_accept && w_last_lane));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_accept && w_last_lane && w_empty) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < INPUT_STREAMS; i++) begin
                r_shift[i] <= '0;
            end
            r_entry_last <= 1'b0;
            r_idx        <= '0;
        end else if (w_pop) begin
            for (int i = 0; i < INPUT_STREAMS; i++) begin
                r_shift[i] <= w_rd_entry[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_entry_last <= w_rd_entry[EW-1];
            r_idx        <= '0;
        end else if (w_accept && !w_last_lane) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_valid      = (r_state == S_SHIFT);
    assign o_data       = o_valid ? r_shift[r_idx] : '0;
    assign o_last       = o_valid && r_entry_last && w_last_lane;
    assign o_overflow   = r_overflow;
    assign o_fifo_level = r_wr_ptr - r_rd_ptr;

endmodule
